tmr_scrub_ctrl: RTL and testbench
=================================

Name: tmr_scrub_ctrl

Overview:
- Triple-redundant holding stage for one 192-bit fused record (12 × 16-bit words) on the fusion-core path.
- Loads a record into three copies and presents the word-wise majority vote downstream over valid/ready.
- Periodically scrubs: writes voted words back into all three copies, counts corrected words and flags uncorrectable ones.
- Instantiates the existing combinational TMR_Voter on its three stored copies.

Parameters:
- SCRUB_PERIOD, 1024: cycles in FULL between scrub events; legal range ≥2.
- CNT_W, 16: width of the corrected-word counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream record valid.
- in_ready  out  1  high in EMPTY only.
- in_data  in  192  record; word i = bits 16i+15:16i.
- out_valid  out  1  voted record available.
- out_ready  in  1  downstream accept.
- out_data  out  192  voted record; combinational from the voter on the stored copies.
- corr_cnt  out  CNT_W  saturating count of corrected words.
- uncorr_sticky  out  1  set on any uncorrectable word; cleared by clr_stat.
- last_err_flags  out  12  voter error flags captured at the last vote event.
- clr_stat  in  1  synchronous clear of corr_cnt, uncorr_sticky and last_err_flags.

Behaviour:
- Reset (async, rst_n=0):
  - state=EMPTY; copies=0; timer=0; corr_cnt=0; uncorr_sticky=0; last_err_flags=0.
  - Therefore in_ready=1, out_valid=0, out_data=0.
- States:
  - EMPTY: in_ready=1, out_valid=0. On in_valid, load in_data into all three copies, clear timer, go to FULL. Latency in→out_valid is 1 cycle.
  - FULL: out_valid=1, timer increments. On out_valid&&out_ready, go to EMPTY. Otherwise, when timer==SCRUB_PERIOD-1, go to SCRUB.
  - SCRUB: one cycle. out_valid stays 1 and out_data is unchanged.
    - Scrubbed words: for each word with error_flag=0, write the voted word into all three copies.
    - Uncorrectable words: words with error_flag=1 are left untouched.
    - Next state: FULL with timer cleared. If out_ready=1 in this cycle, the handshake wins: go to EMPTY and discard the writeback.
- Valid/ready: out_valid never drops before acceptance. out_data stays stable while out_valid=1 and unaccepted, because scrubbing never changes a voted value.
- Vote event: any SCRUB cycle or output handshake cycle. If both occur in the same cycle, count it once.
  - Word i is corrected when the three copies are not all equal and error_flag[i]=0.
  - corr_cnt += popcount(corrected), saturating at 2^CNT_W-1.
  - uncorr_sticky |= |error_flags.
  - last_err_flags <= error_flags.
- clr_stat in the same cycle as a vote event: clear wins, and that event's statistics are dropped.
- in_valid in FULL/SCRUB is ignored (in_ready=0); no overwrite.

Optional Feature:
- Macro: TMR_FAULT_INJECT_EN.
- Defined:
  - Adds ports inj_valid (in, 1), inj_copy (in, 2; 0/1/2 select copy1/2/3; 3 = no-op) and inj_mask (in, 192).
  - In FULL or SCRUB with inj_valid=1, XOR inj_mask into the selected copy.
  - In SCRUB, the XOR is applied on top of that cycle's writeback value.
  - Ignored in EMPTY and on load cycles.
- Undefined: ports absent; copies change only by load or scrub.

Decomposition:
- Package tmr_pkg:
  - TMR_WORDS=12, TMR_WORD_W=16, TMR_REC_W=192.
  - State enum {ST_EMPTY, ST_FULL, ST_SCRUB}.
  - Popcount function for 12-bit vectors.
- One sub-module: the existing TMR_Voter, instantiated once. Controller logic stays in tmr_scrub_ctrl.

Test Plan:
- Reset mid-FULL: rst_n low for 1 cycle → out_valid=0, in_ready=1, out_data=0, corr_cnt=0 asynchronously.
- Clean pass-through: load 192'h0123…; out_ready=1 at cycle 2 → out_data matches, corr_cnt=0, last_err_flags=0, back to EMPTY.
- Single-copy fault (INJECT_EN): inject mask 16'hFFFF into word 3 of copy2, out_ready=0, SCRUB_PERIOD=8 → scrub at timer 7; corr_cnt=1; copy2 word 3 restored; a second scrub adds 0.
- Triple disagreement: inject distinct masks into word 5 of copy1 and copy2, with copy3 clean → at scrub last_err_flags=12'h020, uncorr_sticky=1, out_data word 5 = copy1 value; clr_stat clears everything.
- Scrub/handshake collision: out_ready=1 in the SCRUB cycle with one corrected word → state EMPTY, corr_cnt +1 only once.
- Saturation: CNT_W=4, repeat 12-word corruption twice → corr_cnt=15 and holds.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and constants for the triple-redundant record holding stage.
// Record geometry, controller state encoding and a 12-bit popcount helper.
package tmr_pkg;

  localparam int TMR_WORDS  = 12;
  localparam int TMR_WORD_W = 16;
  localparam int TMR_REC_W  = TMR_WORDS * TMR_WORD_W;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SCRUB
  } tmr_state_e;

  function automatic logic [3:0] popcount12(input logic [TMR_WORDS-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < TMR_WORDS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tmr_scrub_ctrl_voter.sv
// Combinational word-wise 2-of-3 majority voter over three 192-bit copies.
// A word whose three copies all differ is flagged and passes copy_a through.
module TMR_Voter
  import tmr_pkg::*;
(
  input  logic [TMR_REC_W-1:0] copy_a,
  input  logic [TMR_REC_W-1:0] copy_b,
  input  logic [TMR_REC_W-1:0] copy_c,
  output logic [TMR_REC_W-1:0] voted,
  output logic [TMR_WORDS-1:0] err_flags
);

  always_comb begin
    voted     = '0;
    err_flags = '0;
    for (int i = 0; i < TMR_WORDS; i++) begin
      logic [TMR_WORD_W-1:0] wa, wb, wc;
      wa = copy_a[i*TMR_WORD_W +: TMR_WORD_W];
      wb = copy_b[i*TMR_WORD_W +: TMR_WORD_W];
      wc = copy_c[i*TMR_WORD_W +: TMR_WORD_W];
      if ((wa == wb) || (wa == wc)) begin
        voted[i*TMR_WORD_W +: TMR_WORD_W] = wa;
      end else if (wb == wc) begin
        voted[i*TMR_WORD_W +: TMR_WORD_W] = wb;
      end else begin
        voted[i*TMR_WORD_W +: TMR_WORD_W] = wa;
        err_flags[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Triple-redundant holding stage for one 192-bit record with periodic scrubbing.
// Optional fault-injection ports are enabled by defining TMR_FAULT_INJECT_EN.
//
// state    | meaning
// ST_EMPTY | no record held, accepting input
// ST_FULL  | record presented downstream, scrub timer running
// ST_SCRUB | one-cycle vote writeback into all three copies
module tmr_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int SCRUB_PERIOD = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TMR_REC_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TMR_REC_W-1:0] out_data,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic                 uncorr_sticky,
  output logic [TMR_WORDS-1:0] last_err_flags,
  input  logic                 clr_stat
`ifdef TMR_FAULT_INJECT_EN
  ,
  input  logic                 inj_valid,
  input  logic [1:0]           inj_copy,
  input  logic [TMR_REC_W-1:0] inj_mask
`endif
);

  localparam int TMR_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TIMER_TC = TMR_W'(SCRUB_PERIOD - 1);
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  tmr_state_e state_q, state_d;
  logic [TMR_W-1:0]     timer_q;
  logic [TMR_REC_W-1:0] copy1_q, copy2_q, copy3_q;
  logic [TMR_REC_W-1:0] copy1_d, copy2_d, copy3_d;
  logic [TMR_REC_W-1:0] voted;
  logic [TMR_WORDS-1:0] err_flags;
  logic [TMR_REC_W-1:0] err_mask;
  logic [TMR_WORDS-1:0] mismatch;
  logic [TMR_WORDS-1:0] corrected;
  logic [SUM_W-1:0]     corr_sum;
  logic                 load, scrub_wb, timer_clr, timer_inc;
  logic                 handshake, vote_ev;

  TMR_Voter u_voter (
    .copy_a    (copy1_q),
    .copy_b    (copy2_q),
    .copy_c    (copy3_q),
    .voted     (voted),
    .err_flags (err_flags)
  );

  assign out_data = voted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    scrub_wb  = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          timer_clr = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_EMPTY;
        end else if (timer_q == TIMER_TC) begin
          state_d = ST_SCRUB;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ST_SCRUB: begin
        out_valid = 1'b1;
        timer_clr = 1'b1;
        // A handshake in this cycle takes priority and the writeback is dropped.
        if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          scrub_wb = 1'b1;
          state_d  = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         timer_q <= '0;
    else if (timer_clr) timer_q <= '0;
    else if (timer_inc) timer_q <= timer_q + TMR_W'(1);
  end

  always_comb begin
    err_mask = '0;
    mismatch = '0;
    for (int i = 0; i < TMR_WORDS; i++) begin
      err_mask[i*TMR_WORD_W +: TMR_WORD_W] = {TMR_WORD_W{err_flags[i]}};
      mismatch[i] = !((copy1_q[i*TMR_WORD_W +: TMR_WORD_W] == copy2_q[i*TMR_WORD_W +: TMR_WORD_W]) &&
                      (copy2_q[i*TMR_WORD_W +: TMR_WORD_W] == copy3_q[i*TMR_WORD_W +: TMR_WORD_W]));
    end
  end

  // Uncorrectable words keep each copy's own contents during writeback.
  always_comb begin
    copy1_d = copy1_q;
    copy2_d = copy2_q;
    copy3_d = copy3_q;
    if (load) begin
      copy1_d = in_data;
      copy2_d = in_data;
      copy3_d = in_data;
    end else if (scrub_wb) begin
      copy1_d = (voted & ~err_mask) | (copy1_q & err_mask);
      copy2_d = (voted & ~err_mask) | (copy2_q & err_mask);
      copy3_d = (voted & ~err_mask) | (copy3_q & err_mask);
    end
`ifdef TMR_FAULT_INJECT_EN
    if (inj_valid && (state_q != ST_EMPTY)) begin
      case (inj_copy)
        2'd0:    copy1_d = copy1_d ^ inj_mask;
        2'd1:    copy2_d = copy2_d ^ inj_mask;
        2'd2:    copy3_d = copy3_d ^ inj_mask;
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copy1_q <= '0;
      copy2_q <= '0;
      copy3_q <= '0;
    end else begin
      copy1_q <= copy1_d;
      copy2_q <= copy2_d;
      copy3_q <= copy3_d;
    end
  end

  assign handshake = out_valid & out_ready;
  assign vote_ev   = (state_q == ST_SCRUB) | handshake;
  assign corrected = mismatch & ~err_flags;
  assign corr_sum  = SUM_W'(corr_cnt) + SUM_W'(popcount12(corrected));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt       <= '0;
      uncorr_sticky  <= 1'b0;
      last_err_flags <= '0;
    end else if (clr_stat) begin
      corr_cnt       <= '0;
      uncorr_sticky  <= 1'b0;
      last_err_flags <= '0;
    end else if (vote_ev) begin
      corr_cnt       <= (corr_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(corr_sum);
      uncorr_sticky  <= uncorr_sticky | (|err_flags);
      last_err_flags <= err_flags;
    end
  end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Randomized bench for tmr_scrub_ctrl against a word-level reference model.
// Fault-injection scenarios are included when TMR_FAULT_INJECT_EN is defined.
module tb_tmr_scrub_ctrl;

  localparam int P    = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [191:0] out_data;
  logic [CW-1:0] corr_cnt;
  logic         uncorr_sticky;
  logic [11:0]  last_err_flags;
  logic         clr_stat;
`ifdef TMR_FAULT_INJECT_EN
  logic         inj_valid;
  logic [1:0]   inj_copy;
  logic [191:0] inj_mask;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 = no record, 1 = holding, 2 = scrub cycle.
  int          m_phase;
  int          m_timer;
  logic [15:0] m_cp [3][12];
  int          m_corr;
  logic        m_sticky;
  logic [11:0] m_last;

  tmr_scrub_ctrl #(.SCRUB_PERIOD(P), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .corr_cnt       (corr_cnt),
    .uncorr_sticky  (uncorr_sticky),
    .last_err_flags (last_err_flags),
    .clr_stat       (clr_stat)
`ifdef TMR_FAULT_INJECT_EN
    ,
    .inj_valid      (inj_valid),
    .inj_copy       (inj_copy),
    .inj_mask       (inj_mask)
`endif
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_phase = 0; m_timer = 0; m_corr = 0; m_sticky = 1'b0; m_last = '0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 12; i++) m_cp[k][i] = '0;
  endfunction

  function automatic void m_vote(output logic [191:0] v, output logic [11:0] f, output int ncorr);
    v = '0; f = '0; ncorr = 0;
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a, b, c;
      a = m_cp[0][i]; b = m_cp[1][i]; c = m_cp[2][i];
      if (a == b || a == c) v[16*i +: 16] = a;
      else if (b == c)      v[16*i +: 16] = b;
      else begin v[16*i +: 16] = a; f[i] = 1'b1; end
      if (!(a == b && b == c) && !f[i]) ncorr++;
    end
  endfunction

  function automatic void m_step();
    logic [191:0] v;
    logic [11:0]  f;
    int           nc;
    logic         hs, ev;
    m_vote(v, f, nc);
    hs = (m_phase != 0) && out_ready;
    ev = (m_phase == 2) || hs;
    if (clr_stat) begin
      m_corr = 0; m_sticky = 1'b0; m_last = '0;
    end else if (ev) begin
      m_corr = (m_corr + nc > CMAX) ? CMAX : m_corr + nc;
      m_sticky = m_sticky | (|f);
      m_last = f;
    end
    if (m_phase == 0 && in_valid) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 12; i++) m_cp[k][i] = in_data[16*i +: 16];
    end else if (m_phase == 2 && !hs) begin
      for (int i = 0; i < 12; i++)
        if (!f[i]) for (int k = 0; k < 3; k++) m_cp[k][i] = v[16*i +: 16];
    end
`ifdef TMR_FAULT_INJECT_EN
    if (m_phase != 0 && inj_valid && inj_copy != 2'd3)
      for (int i = 0; i < 12; i++)
        m_cp[int'(inj_copy)][i] = m_cp[int'(inj_copy)][i] ^ inj_mask[16*i +: 16];
`endif
    case (m_phase)
      0: if (in_valid) begin m_phase = 1; m_timer = 0; end
      1: if (hs) m_phase = 0;
         else if (m_timer == P - 1) m_phase = 2;
         else m_timer++;
      default: begin m_phase = hs ? 0 : 1; m_timer = 0; end
    endcase
  endfunction

  function automatic logic [191:0] m_out();
    logic [191:0] v;
    logic [11:0]  f;
    int           nc;
    m_vote(v, f, nc);
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; clr_stat = 1'b0; in_data = '0;
`ifdef TMR_FAULT_INJECT_EN
    inj_valid = 1'b0; inj_copy = 2'd3; inj_mask = '0;
`endif
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1; clr_stat = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic run_past_scrub();
    for (int k = 0; k < 4 * P && m_phase != 2; k++) tick();
    tick();
  endtask

  function automatic logic [191:0] rnd_rec();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [191:0] rec;
    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_handshake in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid); end
    n_vec++; if (out_data !== '0 || corr_cnt !== '0 || uncorr_sticky !== 1'b0 || last_err_flags !== '0) begin n_err++;
      $display("FAIL reset_values out_data=%h corr=%0d sticky=%0b last=%h exp all zero", out_data, corr_cnt, uncorr_sticky, last_err_flags); end
    rst_n = 1'b1;
    rec = rnd_rec();
    in_valid = 1'b1; in_data = rec;
    tick();
    idle_inputs();
    repeat (3) tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== rec) begin n_err++;
      $display("FAIL pre_reset_full out_valid=%0b out_data=%h exp 1 %h", out_valid, out_data, rec); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || corr_cnt !== '0) begin n_err++;
      $display("FAIL async_reset out_valid=%0b in_ready=%0b out_data=%h corr=%0d exp 0 1 0 0", out_valid, in_ready, out_data, corr_cnt); end
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    logic [191:0] rec;
    rec = 192'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978;
    drain();
    in_valid = 1'b1; in_data = rec;
    tick();
    idle_inputs();
    n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== rec) begin n_err++;
      $display("FAIL pass_out out_valid=%0b in_ready=%0b out_data=%h exp 1 0 %h", out_valid, in_ready, out_data, rec); end
    out_ready = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || corr_cnt !== '0 || last_err_flags !== '0) begin n_err++;
      $display("FAIL pass_done in_ready=%0b out_valid=%0b corr=%0d last=%h exp 1 0 0 0", in_ready, out_valid, corr_cnt, last_err_flags); end
  endtask

  task automatic test_hold_and_scrub();
    logic [191:0] rec;
    int bad;
    drain();
    rec = rnd_rec();
    in_valid = 1'b1; in_data = rec;
    tick();
    bad = 0;
    for (int c = 0; c < 3 * (P + 1) + 2; c++) begin
      in_valid = 1'b1; in_data = rnd_rec(); out_ready = 1'b0;
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== rec) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++;
      $display("FAIL hold_stable bad_cycles=%0d exp 0 (out_data=%h exp %h)", bad, out_data, rec); end
    n_vec++; if (last_err_flags !== 12'h000 || corr_cnt !== '0) begin n_err++;
      $display("FAIL hold_stats last=%h corr=%0d exp 0 0", last_err_flags, corr_cnt); end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL hold_accept in_ready=%0b exp 1", in_ready); end
  endtask

`ifdef TMR_FAULT_INJECT_EN
  task automatic test_single_fault();
    logic [191:0] rec;
    drain();
    rec = rnd_rec();
    in_valid = 1'b1; in_data = rec;
    tick();
    idle_inputs();
    inj_valid = 1'b1; inj_copy = 2'd1; inj_mask[16*3 +: 16] = 16'hFFFF;
    tick();
    idle_inputs();
    n_vec++; if (out_data !== rec) begin n_err++;
      $display("FAIL single_masked out_data=%h exp %h", out_data, rec); end
    run_past_scrub();
    n_vec++; if (corr_cnt !== CW'(1) || last_err_flags !== '0 || uncorr_sticky !== 1'b0) begin n_err++;
      $display("FAIL single_scrub corr=%0d last=%h sticky=%0b exp 1 0 0", corr_cnt, last_err_flags, uncorr_sticky); end
    run_past_scrub();
    n_vec++; if (corr_cnt !== CW'(1) || out_data !== rec) begin n_err++;
      $display("FAIL single_rescrub corr=%0d out_data=%h exp 1 %h", corr_cnt, out_data, rec); end
  endtask

  task automatic test_triple();
    logic [191:0] rec, exp_d;
    drain();
    rec = rnd_rec();
    in_valid = 1'b1; in_data = rec;
    tick();
    idle_inputs();
    inj_valid = 1'b1; inj_copy = 2'd0; inj_mask[16*5 +: 16] = 16'h00FF;
    tick();
    idle_inputs();
    inj_valid = 1'b1; inj_copy = 2'd1; inj_mask[16*5 +: 16] = 16'h0F00;
    tick();
    idle_inputs();
    exp_d = rec;
    exp_d[16*5 +: 16] = rec[16*5 +: 16] ^ 16'h00FF;
    run_past_scrub();
    n_vec++; if (last_err_flags !== 12'h020 || uncorr_sticky !== 1'b1 || out_data !== exp_d) begin n_err++;
      $display("FAIL triple_scrub last=%h sticky=%0b out_data=%h exp 020 1 %h", last_err_flags, uncorr_sticky, out_data, exp_d); end
    clr_stat = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (last_err_flags !== '0 || uncorr_sticky !== 1'b0 || corr_cnt !== '0) begin n_err++;
      $display("FAIL triple_clear last=%h sticky=%0b corr=%0d exp 0 0 0", last_err_flags, uncorr_sticky, corr_cnt); end
  endtask

  task automatic test_collision();
    drain();
    in_valid = 1'b1; in_data = rnd_rec();
    tick();
    idle_inputs();
    inj_valid = 1'b1; inj_copy = 2'd2; inj_mask[16*9 +: 16] = 16'h8001;
    tick();
    idle_inputs();
    for (int k = 0; k < 4 * P && m_phase != 2; k++) tick();
    out_ready = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (in_ready !== 1'b1 || corr_cnt !== CW'(1)) begin n_err++;
      $display("FAIL collision in_ready=%0b corr=%0d exp 1 1", in_ready, corr_cnt); end
    tick();
    n_vec++; if (corr_cnt !== CW'(1)) begin n_err++;
      $display("FAIL collision_once corr=%0d exp 1", corr_cnt); end
  endtask

  task automatic test_saturation();
    drain();
    in_valid = 1'b1; in_data = rnd_rec();
    tick();
    for (int r = 0; r < 3; r++) begin
      idle_inputs();
      inj_valid = 1'b1; inj_copy = 2'd0; inj_mask = {12{16'h5A5A}};
      tick();
      idle_inputs();
      run_past_scrub();
      n_vec++; if (corr_cnt !== CW'((r == 0) ? 12 : CMAX)) begin n_err++;
        $display("FAIL saturation round=%0d corr=%0d exp %0d", r, corr_cnt, (r == 0) ? 12 : CMAX); end
    end
  endtask
`endif

  task automatic test_random();
    int bad_v, bad_r, bad_d, bad_s;
    logic [191:0] ed;
    drain();
    bad_v = 0; bad_r = 0; bad_d = 0; bad_s = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 5) == 0);
      clr_stat  = ($urandom_range(0, 19) == 0);
      in_data   = rnd_rec();
`ifdef TMR_FAULT_INJECT_EN
      inj_valid = ($urandom_range(0, 3) == 0);
      inj_copy  = 2'($urandom_range(0, 3));
      inj_mask  = '0;
      inj_mask[16*$urandom_range(0, 11) +: 16] = 16'($urandom);
`endif
      tick();
      ed = m_out();
      if (out_valid !== (m_phase != 0)) bad_v++;
      if (in_ready !== (m_phase == 0)) bad_r++;
      if (out_data !== ed) bad_d++;
      if (corr_cnt !== CW'(m_corr) || uncorr_sticky !== m_sticky || last_err_flags !== m_last) bad_s++;
    end
    idle_inputs();
    n_vec++; if (bad_v != 0) begin n_err++; $display("FAIL rand_out_valid bad_cycles=%0d exp 0", bad_v); end
    n_vec++; if (bad_r != 0) begin n_err++; $display("FAIL rand_in_ready bad_cycles=%0d exp 0", bad_r); end
    n_vec++; if (bad_d != 0) begin n_err++; $display("FAIL rand_out_data bad_cycles=%0d exp 0", bad_d); end
    n_vec++; if (bad_s != 0) begin n_err++;
      $display("FAIL rand_stats bad_cycles=%0d exp 0 (corr=%0d/%0d sticky=%0b/%0b last=%h/%h)",
               bad_s, corr_cnt, m_corr, uncorr_sticky, m_sticky, last_err_flags, m_last); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_hold_and_scrub();
`ifdef TMR_FAULT_INJECT_EN
    test_single_fault();
    test_triple();
    test_collision();
    test_saturation();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
